// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types for the EX/MEM pipeline register
package lc3b_types;

    localparam int LC3B_CTRL_W = 32;

    typedef logic [15:0]            lc3b_word;
    typedef logic [2:0]             lc3b_reg;
    typedef logic [LC3B_CTRL_W-1:0] lc3b_control_word;

    typedef struct packed {
        lc3b_word         pc;
        lc3b_control_word ctrl;
        lc3b_reg          dest;
        lc3b_word         alu;
        lc3b_word         store;
    } lc3b_exmem_payload;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } exmem_state_t;

endpackage

// File: rtl/exmem_skid_reg.sv
// rtl/exmem_skid_reg.sv - generic two-entry skid register with valid/ready and flush
module skid_reg
    import lc3b_types::*;
#(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    exmem_state_t state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, consume;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Flush discards a same-edge accept; data regs only move on accept or skid shift.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    head_d  = in_data;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && consume) begin
                        head_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (consume) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = head_q;
        in_ready  = SKID_EN ? (state_q != TWO) : ((state_q == EMPTY) || out_ready);
        case (state_q)
            ONE:     count = 2'd1;
            TWO:     count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    a_no_accept_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == TWO && !out_ready && !flush) |=> (state_q == TWO && $stable(skid_q)));

    a_stable_under_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count != 2'd3);

endmodule

// File: rtl/exmem_skid.sv
// rtl/exmem_skid.sv - EX/MEM pipeline register with skid buffer and flush
module exmem_skid
    import lc3b_types::*;
#(
    parameter int CTRL_W  = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [15:0]       ex_pc,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [2:0]        ex_dest,
    input  logic [15:0]       ex_alu,
    input  logic [15:0]       ex_store,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [15:0]       mem_pc,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [2:0]        mem_dest,
    output logic [15:0]       mem_alu,
    output logic [15:0]       mem_store,
    output logic [1:0]        occupancy
);

    lc3b_exmem_payload in_p, out_p;

    always_comb begin
        in_p.pc    = ex_pc;
        in_p.ctrl  = ex_ctrl;
        in_p.dest  = ex_dest;
        in_p.alu   = ex_alu;
        in_p.store = ex_store;
    end

    assign mem_pc    = out_p.pc;
    assign mem_ctrl  = out_p.ctrl;
    assign mem_dest  = out_p.dest;
    assign mem_alu   = out_p.alu;
    assign mem_store = out_p.store;

    skid_reg #(
        .W       ($bits(lc3b_exmem_payload)),
        .SKID_EN (SKID_EN)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_p),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .out_data  (out_p),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_exmem_skid.sv
// tb/tb_exmem_skid.sv - randomized queue-model bench for exmem_skid
module tb_exmem_skid;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, ex_valid, ex_ready, mem_valid, mem_ready;
    logic [15:0] ex_pc, ex_alu, ex_store, mem_pc, mem_alu, mem_store;
    logic [31:0] ex_ctrl, mem_ctrl;
    logic [2:0]  ex_dest, mem_dest;
    logic [1:0]  occupancy;

    exmem_skid #(.CTRL_W(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_ctrl(ex_ctrl), .ex_dest(ex_dest), .ex_alu(ex_alu), .ex_store(ex_store),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_ctrl(mem_ctrl), .mem_dest(mem_dest), .mem_alu(mem_alu), .mem_store(mem_store),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    lc3b_exmem_payload q[$];
    logic [15:0]       emitted[$];
    lc3b_exmem_payload held;
    bit                stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic lc3b_exmem_payload mk(input logic [15:0] pc, input logic [31:0] ctrl);
        lc3b_exmem_payload p;
        p.pc    = pc;
        p.ctrl  = ctrl;
        p.dest  = 3'($urandom);
        p.alu   = 16'($urandom);
        p.store = 16'($urandom);
        return p;
    endfunction

    task automatic check_outputs();
        chk("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("mem_pc", 64'(mem_pc), 64'(q[0].pc));
            chk("mem_ctrl", 64'(mem_ctrl), 64'(q[0].ctrl));
            chk("mem_dest", 64'(mem_dest), 64'(q[0].dest));
            chk("mem_alu", 64'(mem_alu), 64'(q[0].alu));
            chk("mem_store", 64'(mem_store), 64'(q[0].store));
        end
        if (stall) begin
            chk("hold_data", 64'({mem_pc, mem_ctrl, mem_dest, mem_alu}), 64'({held.pc, held.ctrl, held.dest, held.alu}));
            chk("hold_store", 64'(mem_store), 64'(held.store));
        end
    endtask

    // Called at a falling edge; applies inputs for one cycle and checks the result.
    task automatic step(input bit v, input lc3b_exmem_payload p, input bit mr, input bit fl);
        bit exp_ready, exp_valid;
        ex_valid = v;
        ex_pc = p.pc; ex_ctrl = p.ctrl; ex_dest = p.dest; ex_alu = p.alu; ex_store = p.store;
        mem_ready = mr;
        flush = fl;
        stall = mem_valid && !mr && !fl;
        held = {mem_pc, mem_ctrl, mem_dest, mem_alu, mem_store};
        if (mem_valid && mr) emitted.push_back(mem_pc);
        exp_ready = (q.size() < 2);
        exp_valid = (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (exp_valid && mr) void'(q.pop_front());
            if (v && exp_ready) q.push_back(p);
        end
        @(negedge clk);
        check_outputs();
    endtask

    lc3b_exmem_payload p;

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        ex_pc = '0; ex_ctrl = '0; ex_dest = '0; ex_alu = '0; ex_store = '0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_mem_pc", 64'(mem_pc), 64'd0);
        chk("rst_mem_ctrl", 64'(mem_ctrl), 64'd0);
        rst_n = 1'b1;

        p = mk(16'h3000, 32'h0); p.alu = 16'h1234; p.dest = 3'd5;
        step(1'b1, p, 1'b1, 1'b0);
        chk("t1_pc", 64'(mem_pc), 64'h3000);
        chk("t1_alu", 64'(mem_alu), 64'h1234);
        chk("t1_dest", 64'(mem_dest), 64'd5);
        chk("t1_occ", 64'(occupancy), 64'd1);
        step(1'b0, p, 1'b1, 1'b0);

        emitted.delete();
        step(1'b1, mk(16'h3000, 32'h11), 1'b0, 1'b0);
        step(1'b1, mk(16'h3002, 32'h22), 1'b0, 1'b0);
        chk("t2_full_ready", 64'(ex_ready), 64'd0);
        p = mk(16'h3004, 32'h33);
        step(1'b1, p, 1'b0, 1'b0);
        step(1'b1, p, 1'b0, 1'b0);
        chk("t2_c_blocked", 64'(mem_pc), 64'h3000);
        step(1'b1, p, 1'b1, 1'b0);
        step(1'b1, p, 1'b1, 1'b0);
        step(1'b0, p, 1'b1, 1'b0);
        step(1'b0, p, 1'b1, 1'b0);
        chk("t2_count", 64'(emitted.size()), 64'd3);
        if (emitted.size() == 3) begin
            chk("t2_order0", 64'(emitted[0]), 64'h3000);
            chk("t2_order1", 64'(emitted[1]), 64'h3002);
            chk("t2_order2", 64'(emitted[2]), 64'h3004);
        end

        emitted.delete();
        for (int i = 0; i < 10; i++) step(1'b1, mk(16'(16'h3000 + 2 * i), 32'($urandom)), 1'b1, 1'b0);
        step(1'b0, p, 1'b1, 1'b0);
        chk("t3_count", 64'(emitted.size()), 64'd10);

        emitted.delete();
        step(1'b1, mk(16'h3100, 32'h1), 1'b0, 1'b0);
        step(1'b1, mk(16'h3102, 32'h2), 1'b0, 1'b0);
        step(1'b1, mk(16'h4000, 32'h3), 1'b0, 1'b1);
        chk("t4_valid", 64'(mem_valid), 64'd0);
        chk("t4_ready", 64'(ex_ready), 64'd1);
        repeat (3) step(1'b0, p, 1'b1, 1'b0);
        foreach (emitted[i]) chk("t4_no_4000", 64'(emitted[i] == 16'h4000), 64'd0);

        step(1'b1, mk(16'h3200, 32'hDEADBEEF), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'(i % 2), mk(16'(16'h3300 + i), 32'($urandom)), 1'b0, 1'b0);
            chk("t5_ctrl", 64'(mem_ctrl), 64'hDEADBEEF);
        end
        repeat (3) step(1'b0, p, 1'b1, 1'b0);

        step(1'b1, mk(16'h3400, 32'h4), 1'b0, 1'b0);
        step(1'b1, mk(16'h3402, 32'h5), 1'b0, 1'b0);
        ex_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(mem_valid), 64'd0);
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_ready", 64'(ex_ready), 64'd1);
        chk("t6_pc", 64'(mem_pc), 64'd0);
        q.delete();
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, mk(16'($urandom), 32'($urandom)),
                 ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
